// File: rtl/pa_fadd_lop_pkg.sv
// Shared helpers and width presets for the pipelined FADD close-path leading-one predictor.
// Bit-level G/Z/T derivation and indicator rules live here so every width uses identical logic.
package pa_fadd_lop_pkg;

    localparam int FADD_LOP_W_HALF = 15;
    localparam int FADD_LOP_W_SNGL = 28;
    localparam int FADD_LOP_W_DBL  = 57;

    typedef struct packed {
        logic t;
        logic g;
        logic z;
    } lop_gzt_t;

    // Subtraction is done as A + ~B, so the carry-propagate/generate/kill terms use the inverted subtrahend.
    function automatic lop_gzt_t lop_gzt(input logic a, input logic b);
        lop_gzt_t r;
        logic     c;
        c   = ~b;
        r.t = a ^ c;
        r.g = a & c;
        r.z = ~a & ~c;
        return r;
    endfunction

    function automatic logic lop_ind_msb(input lop_gzt_t cur, input lop_gzt_t dn);
        return (cur.g & ~dn.z) | (cur.z & ~dn.g);
    endfunction

    function automatic logic lop_ind_lsb(input lop_gzt_t cur);
        return cur.g | cur.z;
    endfunction

    function automatic logic lop_ind_mid(input lop_gzt_t up, input lop_gzt_t cur, input lop_gzt_t dn);
        return (up.t & ((cur.g & ~dn.z) | (cur.z & ~dn.g))) |
               (~up.t & ((cur.g & ~dn.g) | (cur.z & ~dn.z)));
    endfunction

endpackage

// File: rtl/pa_fadd_lop_pipe_if.sv
// Operand/result handshake bundle between alignment, the LOP pipe and the normalisation shifter.
// lop_corr only exists when FADD_LOP_CORR_EN is defined.
interface pa_fadd_lop_pipe_if
    import pa_fadd_lop_pkg::*;
#(
    parameter int WIDTH = FADD_LOP_W_SNGL,
    parameter int POS_W = $clog2(WIDTH)
) ();

    logic             lop_flush;
    logic             lop_in_vld;
    logic             lop_in_rdy;
    logic [WIDTH-1:0] src0_adder;
    logic [WIDTH-1:0] src1_adder;
    logic [WIDTH-1:0] ff1_mask;
    logic             lop_out_vld;
    logic             lop_out_rdy;
    logic [POS_W-1:0] ff1_pred;
    logic [POS_W-1:0] ff1_pred_d;
    logic [WIDTH-1:0] ff1_pred_onehot;
    logic             ff1_zero;
`ifdef FADD_LOP_CORR_EN
    logic             lop_corr;
`endif

    modport master (
        output lop_flush, lop_in_vld, src0_adder, src1_adder, ff1_mask, lop_out_rdy,
        input  lop_in_rdy, lop_out_vld, ff1_pred, ff1_pred_d, ff1_pred_onehot, ff1_zero
`ifdef FADD_LOP_CORR_EN
        , input lop_corr
`endif
    );

    modport slave (
        input  lop_flush, lop_in_vld, src0_adder, src1_adder, ff1_mask, lop_out_rdy,
        output lop_in_rdy, lop_out_vld, ff1_pred, ff1_pred_d, ff1_pred_onehot, ff1_zero
`ifdef FADD_LOP_CORR_EN
        , output lop_corr
`endif
    );

endinterface

// File: rtl/pa_fadd_lop_ff1_enc.sv
// Combinational find-first-one from the MSB: MSB-relative index, index-1 (saturating), one-hot and zero flag.
// An all-zero code yields a defined result (index WIDTH-1, empty one-hot) instead of X.
module pa_fadd_lop_ff1_enc #(
    parameter int WIDTH = 28,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_code,
    output logic [POS_W-1:0] o_pred,
    output logic [POS_W-1:0] o_pred_d,
    output logic [WIDTH-1:0] o_onehot,
    output logic             o_zero
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        o_pred   = POS_W'(WIDTH - 1);
        o_onehot = '0;
        o_zero   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_code[i]) begin
                o_pred      = POS_W'(WIDTH - 1 - i);
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_zero      = 1'b0;
            end
        end
        o_pred_d = (o_pred == '0) ? '0 : o_pred - POS_W'(1);
    end

endmodule

// File: rtl/pa_fadd_lop_pipe.sv
// Two-stage pipelined leading-one predictor for the FADD close (subtract) path, any width >= 4.
// Optional prediction-correction output is enabled by defining FADD_LOP_CORR_EN.
module pa_fadd_lop_pipe
    import pa_fadd_lop_pkg::*;
#(
    parameter int WIDTH = FADD_LOP_W_SNGL,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    pa_fadd_lop_pipe_if.slave lop
);

    lop_gzt_t [WIDTH-1:0] w_gzt;
    logic     [WIDTH-1:0] w_ind;
    logic     [WIDTH-1:0] w_code;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gzt
        assign w_gzt[gi] = lop_gzt(lop.src0_adder[gi], lop.src1_adder[gi]);
    end

    assign w_ind[WIDTH-1] = lop_ind_msb(w_gzt[WIDTH-1], w_gzt[WIDTH-2]);
    assign w_ind[0]       = lop_ind_lsb(w_gzt[0]);

    for (genvar gi = 1; gi < WIDTH - 1; gi++) begin : g_ind
        assign w_ind[gi] = lop_ind_mid(w_gzt[gi+1], w_gzt[gi], w_gzt[gi-1]);
    end

    assign w_code = w_ind | lop.ff1_mask;

    logic             r_vld;
    logic             r_loaded;
    logic [WIDTH-1:0] r_code;
    logic             w_in_rdy;
    logic             w_accept;

    assign w_in_rdy       = ~r_vld | lop.lop_out_rdy;
    assign w_accept       = lop.lop_in_vld & w_in_rdy & ~lop.lop_flush & ~cpurst;
    assign lop.lop_in_rdy = w_in_rdy;

    // r_loaded keeps outputs at zero from reset until the first real entry; flush leaves data visible but invalid.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_vld    <= 1'b0;
            r_loaded <= 1'b0;
        end else if (lop.lop_flush) begin
            r_vld    <= 1'b0;
        end else if (w_in_rdy) begin
            r_vld    <= lop.lop_in_vld;
            if (lop.lop_in_vld) begin
                r_loaded <= 1'b1;
            end
        end
    end

`ifdef FADD_LOP_CORR_EN
    logic [WIDTH-1:0] r_src0;
    logic [WIDTH-1:0] r_src1;
`endif

    always_ff @(posedge forever_cpuclk) begin
        if (w_accept) begin
            r_code <= w_code;
`ifdef FADD_LOP_CORR_EN
            r_src0 <= lop.src0_adder;
            r_src1 <= lop.src1_adder;
`endif
        end
    end

    logic [POS_W-1:0] w_pred;
    logic [POS_W-1:0] w_pred_d;
    logic [WIDTH-1:0] w_onehot;
    logic             w_zero;

    pa_fadd_lop_ff1_enc #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_ff1_enc (
        .i_code   (r_code),
        .o_pred   (w_pred),
        .o_pred_d (w_pred_d),
        .o_onehot (w_onehot),
        .o_zero   (w_zero)
    );

    assign lop.lop_out_vld     = r_vld;
    assign lop.ff1_pred        = r_loaded ? w_pred   : '0;
    assign lop.ff1_pred_d      = r_loaded ? w_pred_d : '0;
    assign lop.ff1_pred_onehot = r_loaded ? w_onehot : '0;
    assign lop.ff1_zero        = r_loaded & w_zero;

`ifdef FADD_LOP_CORR_EN
    logic [WIDTH-1:0] w_diff;

    // The indicator can land one bit above the true leading one; a zero at the predicted bit flags that case.
    assign w_diff       = r_src0 - r_src1;
    assign lop.lop_corr = r_loaded & ~w_zero & ~(|(w_diff & w_onehot));
`endif

endmodule

// File: tb/tb_pa_fadd_lop_pipe.sv
// Directed self-checking bench for pa_fadd_lop_pipe at single-precision width (28 bits).
// With FADD_LOP_CORR_EN defined it also checks lop_corr and sweeps random close-path operand pairs.
module tb_pa_fadd_lop_pipe;
    import pa_fadd_lop_pkg::*;

    localparam int WIDTH = FADD_LOP_W_SNGL;
    localparam int POS_W = $clog2(WIDTH);

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;

    always #5 clk = ~clk;

    pa_fadd_lop_pipe_if #(.WIDTH(WIDTH), .POS_W(POS_W)) lopIf ();

    pa_fadd_lop_pipe #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .lop            (lopIf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] mask);
        lopIf.lop_in_vld = vld;
        lopIf.src0_adder = a;
        lopIf.src1_adder = b;
        lopIf.ff1_mask   = mask;
    endtask

    task automatic checkEntry(input string tag, input int pred, input int predD, input logic [WIDTH-1:0] onehot,
                              input logic zero, input logic corr);
        checkOutput({tag, ".vld"}, 64'(lopIf.lop_out_vld), 64'd1);
        checkOutput({tag, ".pred"}, 64'(lopIf.ff1_pred), 64'(pred));
        checkOutput({tag, ".pred_d"}, 64'(lopIf.ff1_pred_d), 64'(predD));
        checkOutput({tag, ".onehot"}, 64'(lopIf.ff1_pred_onehot), 64'(onehot));
        checkOutput({tag, ".zero"}, 64'(lopIf.ff1_zero), 64'(zero));
`ifdef FADD_LOP_CORR_EN
        checkOutput({tag, ".corr"}, 64'(lopIf.lop_corr), 64'(corr));
`else
        if (corr === 1'bx) $display("[TB] note %s: corr expectation undefined", tag);
`endif
    endtask

    task automatic runOne(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] mask, input int pred, input int predD,
                          input logic [WIDTH-1:0] onehot, input logic zero, input logic corr);
        applyStimulus(1'b1, a, b, mask);
        tick();
        applyStimulus(1'b0, '0, '0, '0);
        checkEntry(tag, pred, predD, onehot, zero, corr);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".vld"}, 64'(lopIf.lop_out_vld), 64'd0);
        checkOutput({tag, ".pred"}, 64'(lopIf.ff1_pred), 64'd0);
        checkOutput({tag, ".pred_d"}, 64'(lopIf.ff1_pred_d), 64'd0);
        checkOutput({tag, ".onehot"}, 64'(lopIf.ff1_pred_onehot), 64'd0);
        checkOutput({tag, ".zero"}, 64'(lopIf.ff1_zero), 64'd0);
        checkOutput({tag, ".in_rdy"}, 64'(lopIf.lop_in_rdy), 64'd1);
`ifdef FADD_LOP_CORR_EN
        checkOutput({tag, ".corr"}, 64'(lopIf.lop_corr), 64'd0);
`endif
    endtask

    initial begin
        rst               = 1'b1;
        lopIf.lop_flush   = 1'b0;
        lopIf.lop_out_rdy = 1'b1;
        applyStimulus(1'b0, '0, '0, '0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkCleared("reset");

        // Single entries through an always-ready sink
        runOne("eqNoMask",  28'h1234567, 28'h1234567, 28'h0000000, 27, 26, 28'h0000000, 1'b1, 1'b0);
        runOne("eqMask12",  28'h1234567, 28'h1234567, 28'h0001000, 15, 14, 28'h0001000, 1'b0, 1'b1);
        runOne("maskMsb",   28'h1234567, 28'h0ABCDEF, 28'h8000000,  0,  0, 28'h8000000, 1'b0, 1'b1);
        runOne("diffOne",   28'h0400000, 28'h03FFFFF, 28'h0000000, 27, 26, 28'h0000001, 1'b0, 1'b0);
        runOne("overshoot", 28'h0000008, 28'h0000003, 28'h0000000, 24, 23, 28'h0000008, 1'b0, 1'b1);
        runOne("msbExact",  28'h8000000, 28'h0000000, 28'h0000000,  0,  0, 28'h8000000, 1'b0, 1'b0);
        runOne("maskWins",  28'h0000008, 28'h0000003, 28'h0000400, 17, 16, 28'h0000400, 1'b0, 1'b1);

        // Stall: entry 1 held for three cycles while entry 2 waits at the input
        applyStimulus(1'b1, '0, '0, 28'h8000000);
        tick();
        lopIf.lop_out_rdy = 1'b0;
        applyStimulus(1'b1, '0, '0, 28'h0100000);
        #1;
        checkOutput("stall.in_rdy", 64'(lopIf.lop_in_rdy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkEntry("stallHold", 0, 0, 28'h8000000, 1'b0, 1'b1);
            checkOutput("stallHold.in_rdy", 64'(lopIf.lop_in_rdy), 64'd0);
        end
        lopIf.lop_out_rdy = 1'b1;
        tick();
        checkEntry("drain2", 7, 6, 28'h0100000, 1'b0, 1'b1);
        applyStimulus(1'b1, '0, '0, 28'h0001000);
        tick();
        checkEntry("drain3", 15, 14, 28'h0001000, 1'b0, 1'b1);
        applyStimulus(1'b1, '0, '0, 28'h0000020);
        tick();
        checkEntry("drain4", 22, 21, 28'h0000020, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, '0);
        tick();
        checkOutput("drainEmpty.vld", 64'(lopIf.lop_out_vld), 64'd0);

        // Reset with a valid entry in S2 and another at the input
        applyStimulus(1'b1, 28'h0000008, 28'h0000003, 28'h0000000);
        tick();
        checkOutput("preRst.vld", 64'(lopIf.lop_out_vld), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, '0);
        checkCleared("midRst");

        // Flush with a valid entry in S2 and another at the input
        applyStimulus(1'b1, '0, '0, 28'h0001000);
        tick();
        checkOutput("preFlush.vld", 64'(lopIf.lop_out_vld), 64'd1);
        applyStimulus(1'b1, '0, '0, 28'h8000000);
        lopIf.lop_flush = 1'b1;
        tick();
        lopIf.lop_flush = 1'b0;
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("flush.vld", 64'(lopIf.lop_out_vld), 64'd0);
        tick();
        checkOutput("flushDiscard.vld", 64'(lopIf.lop_out_vld), 64'd0);
        runOne("postFlush", 28'h0400000, 28'h03FFFFF, 28'h0000000, 27, 26, 28'h0000001, 1'b0, 1'b0);

`ifdef FADD_LOP_CORR_EN
        // Random close-path sweep: prediction must be exact or one bit too high, and lop_corr must say which
        for (int n = 0; n < 10000; n++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            logic [WIDTH-1:0] diff;
            int               msb;
            int               truePred;
            a = WIDTH'($urandom);
            if (n % 2 == 0) begin
                a = a | 28'h0000100;
                b = a - WIDTH'($urandom_range(1, 255));
            end else begin
                b = WIDTH'($urandom);
            end
            if (a == b) b = b ^ 28'h0000001;
            if (a < b) begin
                diff = a;
                a    = b;
                b    = diff;
            end
            diff = a - b;
            msb  = 0;
            for (int i = 0; i < WIDTH; i++) begin
                if (diff[i]) msb = i;
            end
            truePred = WIDTH - 1 - msb;
            applyStimulus(1'b1, a, b, '0);
            tick();
            checkOutput("sweepRange", 64'((int'(lopIf.ff1_pred) == truePred) || (int'(lopIf.ff1_pred) == truePred - 1)), 64'd1);
            checkOutput("sweepCorr", 64'(int'(lopIf.ff1_pred) + int'(lopIf.lop_corr)), 64'(truePred));
        end
        applyStimulus(1'b0, '0, '0, '0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
